// File: rtl/sobel_frame_sched.sv
// Frame-level round-robin scheduler sharing one sobel filter between two pixel streams.
// Each granted frame: clear filter, feed PIXEL_COUNT pixels, feed FLUSH_LEN zeros, drain results.
module sobel_frame_sched #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int FLUSH_LEN = WIDTH + 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ch0_empty,
  input  logic [7:0] ch0_dout,
  output logic       ch0_rd_en,
  input  logic       ch1_empty,
  input  logic [7:0] ch1_dout,
  output logic       ch1_rd_en,
  input  logic       filt_rd_en,
  output logic       filt_empty,
  output logic [7:0] filt_dout,
  input  logic       filt_wr_en,
  input  logic [7:0] filt_din,
  output logic       filt_full,
  output logic       out0_wr_en,
  output logic [7:0] out0_din,
  input  logic       out0_full,
  output logic       out1_wr_en,
  output logic [7:0] out1_din,
  input  logic       out1_full,
  output logic       filt_clr,
  output logic       grant,
  output logic       busy,
  output logic       frame_done
);
  localparam int PIXEL_COUNT = WIDTH * HEIGHT;
  localparam int CW = $clog2(PIXEL_COUNT + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0] LAST_PIX   = CW'(PIXEL_COUNT - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [FW-1:0] flush_cnt;
  logic          last_grant;

  logic       g_empty, g_full, pop, flush_rd, out_active, wr;
  logic [7:0] g_dout;
  logic       pref, pref_empty, pick;

  // Everything below is a pure decode of state/grant, so data passes through with no latency.
  assign g_empty    = grant ? ch1_empty : ch0_empty;
  assign g_dout     = grant ? ch1_dout  : ch0_dout;
  assign g_full     = grant ? out1_full : out0_full;
  assign out_active = (state == FEED) || (state == FLUSH) || (state == DRAIN);
  assign pop        = (state == FEED) && filt_rd_en && !g_empty;
  assign flush_rd   = (state == FLUSH) && filt_rd_en;
  assign wr         = out_active && filt_wr_en && !g_full;

  assign ch0_rd_en  = pop && !grant;
  assign ch1_rd_en  = pop && grant;
  assign filt_empty = (state == FEED) ? g_empty : (state != FLUSH);
  assign filt_dout  = (state == FEED) ? g_dout : 8'd0;
  assign filt_full  = out_active ? g_full : 1'b1;
  assign out0_wr_en = wr && !grant;
  assign out1_wr_en = wr && grant;
  assign out0_din   = (out_active && !grant) ? filt_din : 8'd0;
  assign out1_din   = (out_active && grant) ? filt_din : 8'd0;
  assign filt_clr   = (state == CLR);
  assign busy       = (state != IDLE);
  assign frame_done = wr && (out_cnt == LAST_PIX);

  // Prefer the channel that did not own the last frame; fall back to the other one.
  assign pref       = ~last_grant;
  assign pref_empty = pref ? ch1_empty : ch0_empty;
  assign pick       = pref_empty ? ~pref : pref;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      flush_cnt  <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ch0_empty || !ch1_empty) begin
            grant     <= pick;
            in_cnt    <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            state     <= CLR;
          end
        end
        CLR: state <= FEED;
        FEED: begin
          if (pop) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == LAST_PIX) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_rd) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == LAST_FLUSH) state <= DRAIN;
          end
        end
        default: ;
      endcase
      // The final result closes the frame from any state; unfinished flush reads are abandoned.
      if (wr) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_cnt == LAST_PIX) begin
          last_grant <= grant;
          state      <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched with WIDTH=4, HEIGHT=3 (12 pixels, 6 flush zeros).
// The filter is modelled as an identity pipeline that writes once more than 6 reads are pending.
module tb_sobel_frame_sched;
  logic       clock = 1'b0;
  logic       reset;
  logic       ch0_empty, ch1_empty, ch0_rd_en, ch1_rd_en;
  logic [7:0] ch0_dout, ch1_dout;
  logic       filt_rd_en, filt_empty, filt_wr_en, filt_full;
  logic [7:0] filt_dout, filt_din;
  logic       out0_wr_en, out0_full, out1_wr_en, out1_full;
  logic [7:0] out0_din, out1_din;
  logic       filt_clr, grant, busy, frame_done;

  always #5 clock = ~clock;

  sobel_frame_sched #(.WIDTH(4), .HEIGHT(3)) dut (
    .clock(clock), .reset(reset),
    .ch0_empty(ch0_empty), .ch0_dout(ch0_dout), .ch0_rd_en(ch0_rd_en),
    .ch1_empty(ch1_empty), .ch1_dout(ch1_dout), .ch1_rd_en(ch1_rd_en),
    .filt_rd_en(filt_rd_en), .filt_empty(filt_empty), .filt_dout(filt_dout),
    .filt_wr_en(filt_wr_en), .filt_din(filt_din), .filt_full(filt_full),
    .out0_wr_en(out0_wr_en), .out0_din(out0_din), .out0_full(out0_full),
    .out1_wr_en(out1_wr_en), .out1_din(out1_din), .out1_full(out1_full),
    .filt_clr(filt_clr), .grant(grant), .busy(busy), .frame_done(frame_done)
  );

  logic [7:0] ch0_q[$], ch1_q[$], fpipe[$], exp0_q[$], exp1_q[$];
  logic       grant_log[$];
  logic       ch0_hold = 1'b0, ch1_hold = 1'b0, out0_hold = 1'b0, out1_hold = 1'b0;
  logic       toggle_en = 1'b0;
  int checks = 0, errors = 0;
  int clr_cnt = 0, done_cnt = 0, ch0_pops = 0, ch1_pops = 0, frame_pops = 0;
  int flush_reads = 0, wrong_pops = 0, idle_pops = 0, pop_empty = 0, feed_mis = 0;
  int hold_bad = 0, out0_cnt = 0, out1_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (toggle_en) ch0_hold = ~ch0_hold;
    ch0_empty  = (ch0_q.size() == 0) || ch0_hold;
    ch0_dout   = (ch0_q.size() != 0) ? ch0_q[0] : 8'd0;
    ch1_empty  = (ch1_q.size() == 0) || ch1_hold;
    ch1_dout   = (ch1_q.size() != 0) ? ch1_q[0] : 8'd0;
    filt_rd_en = 1'b1;
    filt_wr_en = (fpipe.size() > 6);
    filt_din   = (fpipe.size() != 0) ? fpipe[0] : 8'd0;
    out0_full  = out0_hold;
    out1_full  = out1_hold;
  endtask

  // One clock: drive at negedge, sample/commit 1ns later, then advance to the next negedge.
  task automatic cycle();
    drive_inputs();
    #1;
    if (filt_clr) begin clr_cnt++; fpipe.delete(); frame_pops = 0; end
    if (busy && !filt_clr && frame_pops < 12 && (filt_empty !== (grant ? ch1_empty : ch0_empty)))
      feed_mis++;
    if (out0_hold && (filt_full !== 1'b1 || out0_wr_en)) hold_bad++;
    if (filt_wr_en && !filt_full) void'(fpipe.pop_front());
    if (filt_rd_en && !filt_empty) begin
      if (frame_pops == 12 && filt_dout == 8'd0) flush_reads++;
      fpipe.push_back(filt_dout);
    end
    if (ch0_rd_en) begin
      ch0_pops++; frame_pops++;
      if (ch0_empty) pop_empty++; else void'(ch0_q.pop_front());
      if (grant) wrong_pops++;
      if (!busy) idle_pops++;
    end
    if (ch1_rd_en) begin
      ch1_pops++; frame_pops++;
      if (ch1_empty) pop_empty++; else void'(ch1_q.pop_front());
      if (!grant) wrong_pops++;
      if (!busy) idle_pops++;
    end
    if (out0_wr_en) begin
      out0_cnt++;
      if (exp0_q.size() == 0) check("out0_unexpected", 1, 0);
      else check("out0_data", out0_din, exp0_q.pop_front());
    end
    if (out1_wr_en) begin
      out1_cnt++;
      if (exp1_q.size() == 0) check("out1_unexpected", 1, 0);
      else check("out1_data", out1_din, exp1_q.pop_front());
    end
    if (frame_done) begin done_cnt++; grant_log.push_back(grant); end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_frame();
    int target;
    target = done_cnt + 1;
    for (int i = 0; i < 300 && done_cnt < target; i++) cycle();
    check("frame_timeout", done_cnt, target);
  endtask

  task automatic load(input logic chan, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      if (chan) begin ch1_q.push_back(base + 8'(i)); exp1_q.push_back(base + 8'(i)); end
      else begin ch0_q.push_back(base + 8'(i)); exp0_q.push_back(base + 8'(i)); end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_filt_empty"}, filt_empty, 1);
    check({tag, "_filt_full"}, filt_full, 1);
    check({tag, "_filt_dout"}, filt_dout, 0);
    check({tag, "_rd_en"}, {ch0_rd_en, ch1_rd_en}, 0);
    check({tag, "_wr_en"}, {out0_wr_en, out1_wr_en}, 0);
    check({tag, "_clr_done"}, {filt_clr, frame_done}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fpipe.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int base0, base1, gl;
    reset = 1'b1;
    load(1'b0, 12, 8'd1);
    drive_inputs();
    @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Test 1: single ch0 frame.
    run_frame();
    check("t1_clr_cycles", clr_cnt, 1);
    check("t1_ch0_pops", ch0_pops, 12);
    check("t1_ch1_pops", ch1_pops, 0);
    check("t1_flush_zeros", flush_reads, 6);
    check("t1_out0_writes", out0_cnt, 12);
    check("t1_grant", grant_log[0], 0);
    check("t1_idle_pops", idle_pops, 0);
    cycle();
    check("t1_busy_after", busy, 0);

    // Tests 2/3: both channels loaded from reset, three frames.
    do_reset();
    load(1'b0, 24, 8'h20);
    load(1'b1, 12, 8'h40);
    gl = grant_log.size();
    base0 = out0_cnt; base1 = out1_cnt;
    run_frame();
    check("t2_ch1_untouched", ch1_q.size(), 12);
    run_frame();
    run_frame();
    check("t3_grant0", grant_log[gl], 0);
    check("t3_grant1", grant_log[gl + 1], 1);
    check("t3_grant2", grant_log[gl + 2], 0);
    check("t3_wrong_pops", wrong_pops, 0);
    check("t3_out0_writes", out0_cnt - base0, 24);
    check("t3_out1_writes", out1_cnt - base1, 12);

    // Test 4: out0_full held for 5 cycles mid-frame.
    load(1'b0, 12, 8'h60);
    base0 = out0_cnt;
    for (int i = 0; i < 200 && out0_cnt - base0 < 4; i++) cycle();
    check("t4_reached_4", out0_cnt - base0, 4);
    out0_hold = 1'b1;
    repeat (5) cycle();
    out0_hold = 1'b0;
    check("t4_hold_outputs", hold_bad, 0);
    check("t4_frozen", out0_cnt - base0, 4);
    run_frame();
    check("t4_total", out0_cnt - base0, 12);
    check("t4_exp_drained", exp0_q.size(), 0);

    // Test 5: ch0_empty toggling every cycle.
    load(1'b0, 12, 8'h80);
    base0 = ch0_pops;
    toggle_en = 1'b1;
    run_frame();
    toggle_en = 1'b0;
    ch0_hold = 1'b0;
    check("t5_pops", ch0_pops - base0, 12);
    check("t5_pop_empty", pop_empty, 0);
    check("t5_feed_mirror", feed_mis, 0);
    check("t5_exp_drained", exp0_q.size(), 0);

    // Test 6: reset after 7 pixels of a ch1 frame.
    load(1'b1, 12, 8'hA0);
    base1 = ch1_pops;
    for (int i = 0; i < 100 && ch1_pops - base1 < 7; i++) cycle();
    check("t6_reached_7", ch1_pops - base1, 7);
    check("t6_grant_ch1", grant, 1);
    reset = 1'b1;
    fpipe.delete();
    exp1_q.delete();
    drive_inputs();
    #1;
    check_reset_outputs("t6_reset");
    @(negedge clock);
    load(1'b0, 12, 8'hC0);
    reset = 1'b0;
    gl = grant_log.size();
    run_frame();
    check("t6_first_grant", grant_log[gl], 0);
    check("t6_exp_drained", exp0_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
